// File: rtl/kbd_event_queue.sv
// rtl/kbd_event_queue.sv - PS/2 scan-code change detector feeding a show-ahead make/break event FIFO
module kbd_event_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [15:0]              code,
  input  logic                     clr_ovf,
  input  logic                     ready,
  output logic                     valid,
  output logic [7:0]               key,
  output logic                     brk,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [15:0]   code_q;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [8:0]    mem [DEPTH];
  logic [8:0]    head;
  logic          cand;
  logic          cand_brk;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;

  // A held code yields a single event; all-zero means "no key" and never queues.
  assign cand     = (code != code_q) && (code != 16'h0000);
  assign cand_brk = (code[15:8] == 8'hF0);

  assign full  = (count == FULL);
  assign valid = (count != '0);
  assign pop   = valid && ready;
  // A full queue still takes a new event when the head leaves on the same edge.
  assign push  = cand && (!full || pop);
  assign drop  = cand && full && !pop;

  assign head = mem[rd_ptr];
  assign key  = valid ? head[7:0] : 8'h00;
  assign brk  = valid ? head[8]   : 1'b0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cand_brk, code[7:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_q   <= 16'h0000;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      code_q <= code;
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // A fresh drop wins over a coincident clear.
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_kbd_event_queue.sv
// tb/tb_kbd_event_queue.sv - directed scoreboard bench for kbd_event_queue
module tb_kbd_event_queue;

  logic        clk;
  logic        rst;
  logic [15:0] code;
  logic        clr_ovf;
  logic        ready;
  logic        valid;
  logic [7:0]  key;
  logic        brk;
  logic [2:0]  count;
  logic        overflow;

  int errors = 0;
  int checks = 0;
  logic [8:0] sb[$];

  kbd_event_queue #(.DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .code     (code),
    .clr_ovf  (clr_ovf),
    .ready    (ready),
    .valid    (valid),
    .key      (key),
    .brk      (brk),
    .count    (count),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input logic b, input logic [7:0] k);
    sb.push_back({b, k});
  endtask

  // Scores the head entry if it leaves on the coming edge, then advances one cycle.
  task automatic step();
    logic [8:0] e;
    if (valid && ready) begin
      chk("pop_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("pop_key", key, e[7:0]);
        chk("pop_brk", brk, e[8]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    ready = 1'b1;
    repeat (n) step();
    ready = 1'b0;
    chk("drain_sb_empty", sb.size(), 0);
    chk("drain_count", count, 0);
    chk("drain_valid", valid, 0);
  endtask

  initial begin
    rst = 1'b1;
    code = 16'h0000;
    clr_ovf = 1'b0;
    ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", valid, 0);
    chk("rst_key", key, 8'h00);
    chk("rst_brk", brk, 0);
    chk("rst_count", count, 0);
    chk("rst_overflow", overflow, 0);
    rst = 1'b0;
    step();

    // Make event, then a long hold must not add entries.
    code = 16'h001C;
    sb_push(1'b0, 8'h1C);
    step();
    chk("make_valid", valid, 1);
    chk("make_key", key, 8'h1C);
    chk("make_brk", brk, 0);
    chk("make_count", count, 1);
    repeat (20) step();
    chk("hold_count", count, 1);

    // Break event, then ordered delivery.
    code = 16'hF01C;
    sb_push(1'b1, 8'h1C);
    step();
    chk("brk_count", count, 2);
    drain(2);

    // Overfill: fifth code is dropped.
    for (int i = 0; i < 5; i++) begin
      code = 16'h0015 + 16'(i);
      if (i < 4) sb_push(1'b0, 8'h15 + 8'(i));
      step();
    end
    chk("full_count", count, 4);
    chk("full_overflow", overflow, 1);
    chk("full_head", key, 8'h15);

    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("clr_overflow", overflow, 0);
    chk("clr_count", count, 4);

    // Push into a full queue alongside a pop.
    code = 16'h0022;
    ready = 1'b1;
    sb_push(1'b0, 8'h22);
    step();
    ready = 1'b0;
    chk("pp_count", count, 4);
    chk("pp_overflow", overflow, 0);
    chk("pp_head", key, 8'h16);
    drain(4);

    // Drop coinciding with clear keeps overflow set.
    for (int i = 0; i < 4; i++) begin
      code = 16'h0031 + 16'(i);
      sb_push(1'b0, 8'h31 + 8'(i));
      step();
    end
    code = 16'h0035;
    clr_ovf = 1'b1;
    step();
    chk("drop_clr_overflow", overflow, 1);
    step();
    clr_ovf = 1'b0;
    chk("clr2_overflow", overflow, 0);
    drain(4);

    // Asynchronous reset mid-cycle with entries queued.
    for (int i = 0; i < 3; i++) begin
      code = 16'h0041 + 16'(i);
      step();
    end
    chk("pre_rst_count", count, 3);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_valid", valid, 0);
    chk("arst_count", count, 0);
    chk("arst_overflow", overflow, 0);
    code = 16'h0029;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sb_push(1'b0, 8'h29);
    step();
    chk("post_rst_valid", valid, 1);
    chk("post_rst_key", key, 8'h29);
    repeat (3) step();
    chk("post_rst_count", count, 1);
    drain(1);

    // Streaming through the pointer wrap.
    ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      code = 16'h0050 + 16'(i);
      sb_push(1'b0, 8'h50 + 8'(i));
      for (int j = 0; j < 3; j++) begin
        step();
        chk("wrap_count_le1", 32'(count <= 3'd1), 1);
      end
    end
    code = 16'h0000;
    repeat (3) step();
    chk("zero_code_count", count, 0);
    chk("wrap_sb_empty", sb.size(), 0);
    ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
